// File: rtl/lc3b_types.sv
// Shared LC-3b type package: word/line types, line offset width and the
// state encoding of the physical-memory responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  // Byte offset bits within a 16-byte line
  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the pmem responder: 2^IDX_W x 128-bit lines, one
// synchronous write port and one synchronous read port. The read port
// register is the responder's visible read data, so it carries a reset and
// holds between reads; the storage itself is never reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  lc3b_line         wr_data,
  input  logic             re,
  input  logic [IDX_W-1:0] rd_idx,
  output lc3b_line         rd_data
);

  lc3b_line mem [2**IDX_W];

  // Write port: commit a whole line
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Read port: registered, holds until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory line responder for the LC-3b cache pmem_* port.
// Accepts one line read or write in IDLE, waits LATENCY cycles in BUSY,
// then pulses pmem_resp for one cycle in RESP. Writes win when both
// request lines are high.
// Optional build macro: PMEM_RESP_PROTO_CHECK_EN adds a sticky protocol
// checker driving proto_err; without it proto_err is tied low.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LATENCY        = 10,
  parameter int ADDR_LINE_BITS = 12
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_line pmem_wdata,
  output lc3b_line pmem_rdata,
  output logic     pmem_resp,
  output logic     proto_err
);

  localparam int IDX_LO = LC3B_LINE_OFFSET_BITS;
  localparam int IDX_HI = ADDR_LINE_BITS + LC3B_LINE_OFFSET_BITS - 1;

  typedef struct packed {
    logic                      wr;
    logic [ADDR_LINE_BITS-1:0] idx;
  } req_t;

  lc3b_pmem_state state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  req_t           req_in, req_q;
  lc3b_line       wdata_q;
  logic           accept, done;

  // Offset bits and bits above the line index are deliberately ignored
  logic unused_addr;
  assign unused_addr = ^pmem_address;

  // Incoming request as it would be latched; write has priority
  assign req_in.wr  = pmem_write;
  assign req_in.idx = pmem_address[IDX_HI:IDX_LO];

  // Next-state and latency counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          accept    = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = 8'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch op and line index on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         req_q <= '0;
    else if (accept) req_q <= req_in;
  end

  // Latch write data on acceptance; no reset needed for the payload
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= pmem_wdata;
  end

  // Decoded from state so it drops as soon as rst asserts
  assign pmem_resp = (state == RESP);

  pmem_line_array #(.IDX_W(ADDR_LINE_BITS)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (done &  req_q.wr),
    .wr_idx  (req_q.idx),
    .wr_data (wdata_q),
    .re      (done & ~req_q.wr),
    .rd_idx  (req_q.idx),
    .rd_data (pmem_rdata)
  );

`ifdef PMEM_RESP_PROTO_CHECK_EN
  logic viol;
  logic perr_q;

  // Flag both-high requests, and any drop or change of the request in BUSY
  always_comb begin
    viol = pmem_read & pmem_write;
    if (state == BUSY) begin
      if (!(pmem_read || pmem_write))                         viol = 1'b1;
      else if (req_in.wr != req_q.wr || req_in.idx != req_q.idx) viol = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perr_q <= 1'b0;
    else if (viol) perr_q <= 1'b1;
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: three instances cover the default
// configuration, LATENCY=1, and ADDR_LINE_BITS=8 aliasing.
module tb_pmem_line_responder;
  import lc3b_types::*;

`ifdef PMEM_RESP_PROTO_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  localparam lc3b_line D1  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam lc3b_line D40 = 128'h4040_4040_0000_1111_2222_3333_4444_0040;
  localparam lc3b_line D80 = 128'h8080_8080_5555_6666_7777_8888_9999_0080;
  localparam lc3b_line DA5 = {16{8'hA5}};
  localparam lc3b_line DAL = 128'hC0FF_EE00_DEAD_BEEF_1234_5678_9ABC_0010;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     rd  [3];
  logic     wr  [3];
  lc3b_word ad  [3];
  lc3b_line wd  [3];
  lc3b_line rdt [3];
  logic     rsp [3];
  logic     perr[3];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  pmem_line_responder #(.LATENCY(10), .ADDR_LINE_BITS(12)) u0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(ad[0]), .pmem_wdata(wd[0]), .pmem_rdata(rdt[0]),
    .pmem_resp(rsp[0]), .proto_err(perr[0]));

  pmem_line_responder #(.LATENCY(1), .ADDR_LINE_BITS(12)) u1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(ad[1]), .pmem_wdata(wd[1]), .pmem_rdata(rdt[1]),
    .pmem_resp(rsp[1]), .proto_err(perr[1]));

  pmem_line_responder #(.LATENCY(3), .ADDR_LINE_BITS(8)) u2 (
    .clk(clk), .rst(rst), .pmem_read(rd[2]), .pmem_write(wr[2]),
    .pmem_address(ad[2]), .pmem_wdata(wd[2]), .pmem_rdata(rdt[2]),
    .pmem_resp(rsp[2]), .proto_err(perr[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Well-behaved transaction: hold request until resp, drop it in RESP.
  // lat = cycles from the accepting edge until resp is seen (0 = timeout).
  task automatic txn(input int u, input logic w, input logic r,
                     input lc3b_word a, input lc3b_line d, output int l);
    @(negedge clk);
    rd[u] = r; wr[u] = w; ad[u] = a; wd[u] = d;
    l = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (rsp[u]) begin l = i; break; end
    end
    rd[u] = 1'b0; wr[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_resp",  128'(rsp[i]),  '0);
      chk("rst_rdata", rdt[i],        '0);
      chk("rst_perr",  128'(perr[i]), '0);
    end
    chk("rst_state", 128'(u0.state), 128'(IDLE));
    @(negedge clk); rst = 1'b0;

    // Write then read with offset bits differing
    txn(0, 1'b1, 1'b0, 16'h1230, D1, lat);
    chk("wr_lat", 128'(lat), 128'd11);
    chk("wr_keeps_rdata", rdt[0], '0);
    txn(0, 1'b0, 1'b1, 16'h123C, '0, lat);
    chk("rd_lat", 128'(lat), 128'd11);
    chk("rd_data", rdt[0], D1);

    txn(0, 1'b1, 1'b0, 16'h0040, D40, lat);
    txn(0, 1'b1, 1'b0, 16'h0080, D80, lat);
    chk("perr_clean", 128'(perr[0]), '0);

    // Address switched mid-BUSY: latched address wins
    @(negedge clk);
    rd[0] = 1'b1; ad[0] = 16'h0040;
    @(posedge clk); @(posedge clk); #1;
    ad[0] = 16'h0080;
    lat = 0;
    for (int i = 3; i <= 300; i++) begin
      @(posedge clk); #1;
      if (rsp[0]) begin lat = i; break; end
    end
    rd[0] = 1'b0;
    chk("sw_lat", 128'(lat), 128'd11);
    chk("sw_data", rdt[0], D40);
    chk("sw_perr", 128'(perr[0]), 128'(PERR_EXP));
    @(posedge clk); #1;

    // Both high: the write is performed
    txn(0, 1'b1, 1'b1, 16'h2000, DA5, lat);
    chk("both_lat", 128'(lat), 128'd11);
    chk("both_keeps_rdata", rdt[0], D40);
    txn(0, 1'b0, 1'b1, 16'h2000, '0, lat);
    chk("both_rd", rdt[0], DA5);

    // LATENCY=1, request held through RESP
    txn(1, 1'b1, 1'b0, 16'h0100, D80, lat);
    chk("l1_wr_lat", 128'(lat), 128'd2);
    @(negedge clk);
    rd[1] = 1'b1; ad[1] = 16'h0100;
    @(posedge clk); #1; chk("l1_c1", 128'(rsp[1]), 128'd0);
    @(posedge clk); #1; chk("l1_c2", 128'(rsp[1]), 128'd1);
    @(posedge clk); #1; chk("l1_c3", 128'(rsp[1]), 128'd0);
    rd[1] = 1'b0;
    chk("l1_data", rdt[1], D80);
    @(posedge clk); #1; chk("l1_c4", 128'(rsp[1]), 128'd0);

    // Aliasing with 8 index bits
    txn(2, 1'b1, 1'b0, 16'h0010, DAL, lat);
    chk("al_wr_lat", 128'(lat), 128'd4);
    txn(2, 1'b0, 1'b1, 16'h1010, '0, lat);
    chk("al_rd_lat", 128'(lat), 128'd4);
    chk("al_data", rdt[2], DAL);

    // Reset mid-write: lost write, committed write survives
    txn(0, 1'b1, 1'b0, 16'h3000, 128'h1, lat);
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 16'h3000; wd[0] = 128'h2;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 128'(u0.state), 128'(BUSY));
    rst = 1'b1;
    #1;
    chk("mid_rst_resp",  128'(rsp[0]),   '0);
    chk("mid_rst_rdata", rdt[0],         '0);
    chk("mid_rst_perr",  128'(perr[0]),  '0);
    chk("mid_rst_state", 128'(u0.state), 128'(IDLE));
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 1'b1, 16'h3000, '0, lat);
    chk("rst_rd_lat", 128'(lat), 128'd11);
    chk("rst_rd_data", rdt[0], 128'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
